adder_trio_unit: RTL and testbench
==================================

Name: adder_trio_unit

Overview:
- Registered arithmetic block computing the same addition with three architectures: behavioural "+" adder, carry-save adder (3-operand reduction plus final carry-propagate stage), and carry-select adder.
- Used as a datapath adder with built-in cross-check. The carry-select result is compared against the behavioural result every sample, and a mismatch flag is raised on disagreement.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4 and a multiple of BLK.
- BLK, 4, carry-select block width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  samples operands this cycle.
- a  in  WIDTH  operand A (unsigned / two's complement, bit pattern identical).
- b  in  WIDTH  operand B.
- c  in  WIDTH  third operand, used only by the carry-save path.
- cin  in  1  carry-in, used by the plus and carry-select paths.
- out_valid  out  1  results valid.
- plus_sum  out  WIDTH  behavioural a+b+cin, low WIDTH bits.
- plus_cout  out  1  carry out of bit WIDTH-1 of a+b+cin.
- csa_sum  out  WIDTH+1  low WIDTH+1 bits of a+b+c.
- csa_cout  out  1  bit WIDTH+1 of a+b+c.
- sel_sum  out  WIDTH  carry-select a+b+cin, low WIDTH bits.
- sel_cout  out  1  carry out of the carry-select adder.
- mismatch  out  1  {sel_cout,sel_sum} != {plus_cout,plus_sum}.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert usage): all outputs are 0, including out_valid and mismatch.
- Latency is 1 cycle.
  - On a rising clk with in_valid=1, all results are computed combinationally from a/b/c/cin and registered.
  - out_valid=1 in the following cycle.
- When in_valid=0, out_valid drops to 0 next cycle and the result registers hold their previous values.
- Back-to-back in_valid gives one result per cycle with no bubbles.
- Plus path: {plus_cout,plus_sum} = a + b + cin, computed at WIDTH+1 bits. It is unsigned carry, not signed overflow.
  - Example: 7fffffff+1 gives cout 0.
  - Example: ffffffff+80000000 gives 7fffffff with cout 1.
- Carry-save path:
  - A row of WIDTH full adders produces sum vector s = a^b^c and carry vector k = majority(a,b,c).
  - A ripple carry-propagate stage then adds s and (k<<1), giving a WIDTH+2-bit result {csa_cout,csa_sum}.
  - This equals a+b+c exactly; cin is ignored.
  - With c=0, csa_sum[WIDTH] equals plus_cout when cin=0.
- Carry-select path:
  - Bits are split into WIDTH/BLK blocks.
  - Block 0 is a plain ripple block fed by cin.
  - Each higher block computes two ripple sums, one with carry-in 0 and one with carry-in 1.
  - The previous block's carry muxes both the sum and the carry-out.
  - sel_cout is the carry out of the top block.
- Wrap-around: all sums are modulo 2^WIDTH on the *_sum outputs, and the excess appears only on the cout bits.
- mismatch is registered alongside the results. It is never asserted for a correct implementation and exists for in-system checking.
- Reset asserted mid-stream clears outputs immediately; the pending sample is lost.

Decomposition:
- Shared package: default WIDTH=32, BLK=4 constants.
- Natural sub-module: csel_block. It is a BLK-bit dual ripple adder with a carry mux, instantiated WIDTH/BLK-1 times.
- Full-adder logic stays inline.

Test Plan:
- Reset: rst=1 mid-run → all outputs 0 immediately; after release with in_valid=0, out_valid stays 0.
- a=7fffffff, b=00000001, c=0, cin=0 → plus_sum=sel_sum=80000000, plus_cout=sel_cout=0, csa_sum=0_80000000, csa_cout=0, mismatch=0, one cycle after sample.
- a=ffffffff, b=80000000, c=0, cin=0 → plus_sum=sel_sum=7fffffff, couts=1, csa_sum=1_7fffffff, csa_cout=0.
- a=00000002, b=fffffffb → fffffffd, cout 0.
- a=fffffffb, b=fffffff4 → ffffffef, cout 1.
- a=c, b=19 → 25; a=7, b=8 → f; a=0, b=a → a. All checked back-to-back with in_valid held high, one result per cycle.
- a=b=c=ffffffff, cin=1:
  - csa: {csa_cout,csa_sum} = 2_fffffffd (csa_cout=1, csa_sum=0_fffffffd).
  - plus/sel: sum ffffffff, cout 1.
  - mismatch=0.

Source files
------------

// File: rtl/adder_trio_unit_pkg.sv
// Shared constants for the adder trio: default operand width and the
// carry-select block width used by the top and its block sub-module.
package adder_trio_unit_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_BLK   = 4;

endpackage

// File: rtl/adder_trio_unit_csel_block.sv
// One carry-select block: two ripple adders run in parallel with carry-in
// assumed 0 and 1, and the real incoming carry picks the sum and carry-out.
module adder_trio_unit_csel_block
   import adder_trio_unit_pkg::*;
#(
   parameter int BLK = DEFAULT_BLK
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           carry_in,
   output logic [BLK-1:0] sum,
   output logic           carry_out
);

   logic [BLK-1:0] sum_c0;
   logic [BLK-1:0] sum_c1;
   logic           cout_c0;
   logic           cout_c1;

   // Both speculative ripple chains, evaluated before the block's carry arrives.
   always_comb begin
      logic carry0;
      logic carry1;
      carry0 = 1'b0;
      carry1 = 1'b1;
      sum_c0 = '0;
      sum_c1 = '0;
      for (int i = 0; i < BLK; i++) begin
         sum_c0[i] = a[i] ^ b[i] ^ carry0;
         carry0    = (a[i] & b[i]) | (a[i] & carry0) | (b[i] & carry0);
         sum_c1[i] = a[i] ^ b[i] ^ carry1;
         carry1    = (a[i] & b[i]) | (a[i] & carry1) | (b[i] & carry1);
      end
      cout_c0 = carry0;
      cout_c1 = carry1;
   end

   // The carry from the block below selects between the two precomputed results.
   always_comb begin
      sum       = carry_in ? sum_c1  : sum_c0;
      carry_out = carry_in ? cout_c1 : cout_c0;
   end

endmodule

// File: rtl/adder_trio_unit.sv
// Registered adder computing a+b+cin (behavioural and carry-select) and
// a+b+c (carry-save), with a cross-check flag comparing the two a+b+cin paths.
module adder_trio_unit
   import adder_trio_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int BLK   = DEFAULT_BLK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] plus_sum,
   output logic             plus_cout,
   output logic [WIDTH:0]   csa_sum,
   output logic             csa_cout,
   output logic [WIDTH-1:0] sel_sum,
   output logic             sel_cout,
   output logic             mismatch
);

   localparam int NBLK = WIDTH / BLK;

   logic [WIDTH:0]   plus_full;
   logic [WIDTH+1:0] csa_full;
   logic [WIDTH-1:0] csa_s;
   logic [WIDTH-1:0] csa_k;
   logic [WIDTH-1:0] sel_sum_c;
   logic [NBLK:0]    blk_carry;
   logic [BLK-1:0]   b0_sum;
   logic             b0_cout;
   logic             mismatch_c;

   // Reference path: let synthesis pick the adder, carry kept as the extra bit.
   always_comb begin
      plus_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   end

   // Carry-save row reduces three operands to sum and carry vectors, then a
   // ripple stage adds s and k<<1 at full width so nothing of a+b+c is lost.
   always_comb begin
      logic carry;
      logic [WIDTH:0] s_ext;
      logic [WIDTH:0] k_ext;
      csa_s = a ^ b ^ c;
      csa_k = (a & b) | (a & c) | (b & c);
      s_ext = {1'b0, csa_s};
      k_ext = {csa_k, 1'b0};
      csa_full = '0;
      carry = 1'b0;
      for (int i = 0; i <= WIDTH; i++) begin
         csa_full[i] = s_ext[i] ^ k_ext[i] ^ carry;
         carry       = (s_ext[i] & k_ext[i]) | (s_ext[i] & carry) | (k_ext[i] & carry);
      end
      csa_full[WIDTH+1] = carry;
   end

   // Lowest carry-select block has a known carry-in, so a single ripple suffices.
   always_comb begin
      logic carry;
      b0_sum = '0;
      carry  = cin;
      for (int i = 0; i < BLK; i++) begin
         b0_sum[i] = a[i] ^ b[i] ^ carry;
         carry     = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end
      b0_cout = carry;
   end

   assign blk_carry[0]        = cin;
   assign blk_carry[1]        = b0_cout;
   assign sel_sum_c[BLK-1:0]  = b0_sum;

   for (genvar g = 1; g < NBLK; g++) begin : gen_csel
      adder_trio_unit_csel_block #(
         .BLK(BLK)
      ) u_blk (
         .a        (a[g*BLK +: BLK]),
         .b        (b[g*BLK +: BLK]),
         .carry_in (blk_carry[g]),
         .sum      (sel_sum_c[g*BLK +: BLK]),
         .carry_out(blk_carry[g+1])
      );
   end

   // Disagreement between the carry-select result and the reference.
   always_comb begin
      mismatch_c = {blk_carry[NBLK], sel_sum_c} != plus_full;
   end

   // Result registers: capture only on valid samples, valid flag tracks in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         plus_sum  <= '0;
         plus_cout <= 1'b0;
         csa_sum   <= '0;
         csa_cout  <= 1'b0;
         sel_sum   <= '0;
         sel_cout  <= 1'b0;
         mismatch  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            plus_sum  <= plus_full[WIDTH-1:0];
            plus_cout <= plus_full[WIDTH];
            csa_sum   <= csa_full[WIDTH:0];
            csa_cout  <= csa_full[WIDTH+1];
            sel_sum   <= sel_sum_c;
            sel_cout  <= blk_carry[NBLK];
            mismatch  <= mismatch_c;
         end
      end
   end

endmodule

// File: tb/tb_adder_trio_unit.sv
// Directed testbench for adder_trio_unit with hand-computed expected results.
module tb_adder_trio_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] c;
   logic        cin;
   logic        out_valid;
   logic [31:0] plus_sum;
   logic        plus_cout;
   logic [32:0] csa_sum;
   logic        csa_cout;
   logic [31:0] sel_sum;
   logic        sel_cout;
   logic        mismatch;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        cin;
      logic [32:0] exp_plus;
      logic [33:0] exp_csa;
   } vec_t;

   vec_t vecs[9];

   adder_trio_unit dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .c        (c),
      .cin      (cin),
      .out_valid(out_valid),
      .plus_sum (plus_sum),
      .plus_cout(plus_cout),
      .csa_sum  (csa_sum),
      .csa_cout (csa_cout),
      .sel_sum  (sel_sum),
      .sel_cout (sel_cout),
      .mismatch (mismatch)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vc, input logic vcin);
      in_valid = v;
      a        = va;
      b        = vb;
      c        = vc;
      cin      = vcin;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_plus"}, 64'({plus_cout, plus_sum}), 64'd0);
      checkOutput({tag, "_sel"}, 64'({sel_cout, sel_sum}), 64'd0);
      checkOutput({tag, "_csa"}, 64'({csa_cout, csa_sum}), 64'd0);
      checkOutput({tag, "_mismatch"}, 64'(mismatch), 64'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0] = '{32'h7fffffff, 32'h00000001, 32'h0, 1'b0, 33'h0_80000000, 34'h0_80000000};
      vecs[1] = '{32'hffffffff, 32'h80000000, 32'h0, 1'b0, 33'h1_7fffffff, 34'h1_7fffffff};
      vecs[2] = '{32'h00000002, 32'hfffffffb, 32'h0, 1'b0, 33'h0_fffffffd, 34'h0_fffffffd};
      vecs[3] = '{32'hfffffffb, 32'hfffffff4, 32'h0, 1'b0, 33'h1_ffffffef, 34'h1_ffffffef};
      vecs[4] = '{32'h0000000c, 32'h00000019, 32'h0, 1'b0, 33'h0_00000025, 34'h0_00000025};
      vecs[5] = '{32'h00000007, 32'h00000008, 32'h0, 1'b0, 33'h0_0000000f, 34'h0_0000000f};
      vecs[6] = '{32'h00000000, 32'h0000000a, 32'h0, 1'b0, 33'h0_0000000a, 34'h0_0000000a};
      vecs[7] = '{32'h00000001, 32'h00000002, 32'h3, 1'b1, 33'h0_00000004, 34'h0_00000006};
      vecs[8] = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 1'b1, 33'h1_ffffffff, 34'h2_fffffffd};

      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      checkAllZero("reset");

      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_reset_valid", 64'(out_valid), 64'd0);

      // Back-to-back stream, one result checked per cycle.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cin);
         @(negedge clk);
         checkOutput($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
         checkOutput($sformatf("v%0d_plus", i), 64'({plus_cout, plus_sum}), 64'(vecs[i].exp_plus));
         checkOutput($sformatf("v%0d_sel", i), 64'({sel_cout, sel_sum}), 64'(vecs[i].exp_plus));
         checkOutput($sformatf("v%0d_csa", i), 64'({csa_cout, csa_sum}), 64'(vecs[i].exp_csa));
         checkOutput($sformatf("v%0d_mismatch", i), 64'(mismatch), 64'd0);
      end

      // Idle cycle: valid drops, results hold the last sample.
      applyStimulus(1'b0, 32'h12345678, 32'h11111111, 32'h22222222, 1'b0);
      @(negedge clk);
      checkOutput("hold_valid", 64'(out_valid), 64'd0);
      checkOutput("hold_plus", 64'({plus_cout, plus_sum}), 64'h1_ffffffff);
      checkOutput("hold_csa", 64'({csa_cout, csa_sum}), 64'h2_fffffffd);

      // Mid-stream reset: load a sample, then reset while another is pending.
      applyStimulus(1'b1, 32'h00000005, 32'h00000006, 32'h00000007, 1'b0);
      @(negedge clk);
      checkOutput("pre_reset_plus", 64'({plus_cout, plus_sum}), 64'h0_0000000b);
      checkOutput("pre_reset_csa", 64'({csa_cout, csa_sum}), 64'h0_00000012);
      applyStimulus(1'b1, 32'h00000100, 32'h00000200, 32'h0, 1'b0);
      rst = 1'b1;
      #1;
      checkAllZero("midreset");
      @(negedge clk);
      checkAllZero("midreset_held");
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
